// File: rtl/div_radix4_param.sv
// Iterative radix-4 integer divider for the EX stage (DIV/DIVU).
// Retires two quotient bits per cycle and reports {remainder, quotient} with a divide-by-zero flag.
module div_radix4_param #(
    parameter int WIDTH = 32
) (
    input  logic               cpu_clk_75M,
    input  logic               cpu_rst_n,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   div_opdata1,
    input  logic [WIDTH-1:0]   div_opdata2,
    input  logic               div_start,
    input  logic               div_cancel,
    output logic [2*WIDTH-1:0] div_result,
    output logic               div_ready,
    output logic               div_busy,
    output logic               div_by_zero
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_q, dbz_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 dbz_out_q, dbz_out_d;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH+1:0]     shifted, dvs_x1, dvs_x2, dvs_x3;
    logic [WIDTH+2:0]     diff1, diff2, diff3;
    logic [1:0]           digit;
    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic                 unused_bits;

    always_comb begin
        sign_a = signed_div_i & div_opdata1[WIDTH-1];
        sign_b = signed_div_i & div_opdata2[WIDTH-1];
        mag_a  = sign_a ? -div_opdata1 : div_opdata1;
        mag_b  = sign_b ? -div_opdata2 : div_opdata2;
    end

    // One radix-4 step: pick the largest multiple of D that fits in the shifted remainder.
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1 -: 2]};
        dvs_x1   = {2'b00, dvs_q};
        dvs_x2   = {1'b0, dvs_q, 1'b0};
        dvs_x3   = dvs_x2 + dvs_x1;
        diff1    = {1'b0, shifted} - {1'b0, dvs_x1};
        diff2    = {1'b0, shifted} - {1'b0, dvs_x2};
        diff3    = {1'b0, shifted} - {1'b0, dvs_x3};
        digit    = 2'd0;
        rem_step = shifted[WIDTH-1:0];
        if (!diff3[WIDTH+2]) begin
            digit    = 2'd3;
            rem_step = diff3[WIDTH-1:0];
        end else if (!diff2[WIDTH+2]) begin
            digit    = 2'd2;
            rem_step = diff2[WIDTH-1:0];
        end else if (!diff1[WIDTH+2]) begin
            digit    = 2'd1;
            rem_step = diff1[WIDTH-1:0];
        end
    end

    assign unused_bits = ^{diff1[WIDTH+1:WIDTH], diff2[WIDTH+1:WIDTH], diff3[WIDTH+1:WIDTH]};

    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        // NOTE: every _d takes its hold value first so no branch can infer a latch.
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        result_d  = result_q;
        ready_d   = ready_q;
        dbz_out_d = dbz_out_q;

        case (state_q)
            S_IDLE: begin
                if (div_start && !div_cancel) begin
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    dvs_d     = mag_b;
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = '0;
                    if (div_opdata2 == '0) begin
                        // The raw dividend is kept for the defined divide-by-zero remainder.
                        dbz_d   = 1'b1;
                        dvd_d   = div_opdata1;
                        state_d = S_FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        dvd_d   = mag_a;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_step;
                quo_d = {quo_q[WIDTH-3:0], digit};
                dvd_d = dvd_q << 2;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d  = dbz_q ? {dvd_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
                ready_d   = 1'b1;
                dbz_out_d = dbz_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (!div_start) begin
                    result_d  = '0;
                    ready_d   = 1'b0;
                    dbz_out_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush wins over everything, including a start in the same cycle.
        if (div_cancel) begin
            state_d   = S_IDLE;
            result_d  = '0;
            ready_d   = 1'b0;
            dbz_out_d = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= S_IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values of the others.
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign div_result  = result_q;
    assign div_ready   = ready_q;
    assign div_by_zero = dbz_out_q;
    assign div_busy    = (state_q != S_IDLE);

endmodule
